sm_dispatch_ctrl: RTL
=====================

// Module: sm_dispatch_ctrl
// PURPOSE
//  Scheduler between the host target stream and the SM feeder / scoring-module pair.
//  Accepts target records over valid/ready and issues one-cycle ld pulses only while the feeder is not full.
//  Pairs each per-toggle score with its ID by popping the feeder ID FIFOs (re0/re1).
//  Emits {id, score} results on a buffered valid/ready stream.
//  Rate-limits loads so that every in-flight result is guaranteed buffer space.
// PARAMETERS
//  TARGET_LENGTH  128  target length in bases (2 bits/base)
//  LEN_WIDTH      12   length field width
//  ID_WIDTH       48   sequence ID width
//  IN_WIDTH       ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH  record width {id,len,target}
//  SCORE_WIDTH    16   score width from scoring module
//  OUT_DEPTH      4    result FIFO depth (power of 2, >=2)
// PORTS
//  clk           in   1            clock, all logic on posedge
//  rst           in   1            asynchronous active-low reset
//  in_valid      in   1            host record valid
//  in_ready      out  1            record accepted when in_valid&in_ready
//  in_data       in   IN_WIDTH     host record
//  ld            out  1            load strobe to feeder
//  feed_out      out  IN_WIDTH     record to feeder feed_in
//  feeder_full   in   1            feeder full flag
//  res_valid0    in   1            scoring module toggle-0 result pulse
//  res_valid1    in   1            scoring module toggle-1 result pulse
//  score0/score1 in   SCORE_WIDTH  result values, valid with res_valid0/1
//  id0/id1       in   ID_WIDTH     feeder ID FIFO heads
//  re0/re1       out  1            feeder ID FIFO read enables
//  out_valid     out  1            result FIFO not empty
//  out_ready     in   1            downstream accepts result
//  out_id        out  ID_WIDTH     result ID (FIFO head)
//  out_score     out  SCORE_WIDTH  result score (FIFO head)
//  busy          out  1            outstanding!=0 | out_valid | state!=IDLE
//  err           out  1            sticky: result pulse with outstanding==0
// BEHAVIOUR
//  Reset values: ld, re0, re1, out_valid, busy and err are 0; feed_out is 0.
//  Reset clears the FSM to IDLE, outstanding to 0, the result FIFO and the pend register.
//  A mid-operation reset discards all in-flight state.
//  FSM IDLE->LOAD->GUARD->IDLE:
//   IDLE:  in_ready = ~feeder_full & (outstanding + fifo_count + pend < OUT_DEPTH).
//          On handshake, register in_data into feed_out and go to LOAD.
//   LOAD:  ld=1 for exactly 1 cycle; outstanding+1; go to GUARD.
//   GUARD: 1 idle cycle so feeder_full reflects the load; in_ready=0; go to IDLE.
//   Maximum load rate is 1 record per 3 cycles. feed_out holds its value until the next accept.
//  Result capture (same cycle as the pulse, 0 latency):
//   res_valid0 -> re0=1, write {id0,score0}.
//   res_valid1 -> re1=1, write {id1,score1}.
//   Each capture decrements outstanding.
//  Simultaneous res_valid0 and res_valid1:
//   Both re0 and re1 pulse in the same cycle.
//   Lane 0 is written to the FIFO; lane 1 goes to the 1-entry pend register.
//   pend is written to the FIFO on the next cycle, ahead of any new lane-1/lane-0 write.
//   A new result arriving that cycle is written after pend, via pend again.
//   Ordering is therefore lane0, lane1, then later arrivals.
//  Credit rule: outstanding + fifo_count + pend <= OUT_DEPTH always, so no result is ever dropped.
//  A same-cycle FIFO pop and push is allowed at full depth.
//  Result pulse with outstanding==0: err <= 1 (cleared only by reset). No write, no re, and
//   outstanding stays 0 (saturate).
//  outstanding width is clog2(OUT_DEPTH)+1. It never wraps.
//  out_valid/out_id/out_score come from the FIFO head (registered). A pop occurs on out_valid&out_ready.
// TESTING
//  1. Reset mid-LOAD: assert rst low during ld=1 -> next cycle ld=0, in_ready=1, busy=0.
//  2. Single record id=0x1234, feeder_full=0 -> ld one cycle 2 clk after accept, feed_out==record;
//     res_valid0, score0=0x0050 -> re0 pulse, out {0x1234,0x0050}.
//  3. Hold feeder_full=1 with in_valid=1 -> in_ready=0, ld never pulses; release -> single ld.
//  4. out_ready=0, 4 loads issued -> 5th record blocked (in_ready=0).
//     Return 4 results -> no loss; drain order matches arrival.
//  5. res_valid0 and res_valid1 same cycle (ids A,B) -> re0=re1=1 that cycle, out order A then B.
//  6. res_valid1 with outstanding==0 -> err=1, no FIFO write, re1=0.

Source files
------------

// File: rtl/sm_dispatch_ctrl_if.sv
// Host/feeder/scorer/result signal bundle for sm_dispatch_ctrl.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes.
interface sm_dispatch_ctrl_if #(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int SCORE_WIDTH   = 16,
    parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH
) ();
    // host record stream
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    in_data;
    // feeder side
    logic                   ld;
    logic [IN_WIDTH-1:0]    feed_out;
    logic                   feeder_full;
    // scoring module side
    logic                   res_valid0;
    logic                   res_valid1;
    logic [SCORE_WIDTH-1:0] score0;
    logic [SCORE_WIDTH-1:0] score1;
    logic [ID_WIDTH-1:0]    id0;
    logic [ID_WIDTH-1:0]    id1;
    logic                   re0;
    logic                   re1;
    // result stream
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_WIDTH-1:0]    out_id;
    logic [SCORE_WIDTH-1:0] out_score;
    // status
    logic                   busy;
    logic                   err;

    // Environment side (host, feeder, scorer, downstream sink)
    modport master (
        output in_valid, in_data, feeder_full, res_valid0, res_valid1,
               score0, score1, id0, id1, out_ready,
        input  in_ready, ld, feed_out, re0, re1, out_valid, out_id,
               out_score, busy, err
    );

    // Dispatch controller side
    modport slave (
        input  in_valid, in_data, feeder_full, res_valid0, res_valid1,
               score0, score1, id0, id1, out_ready,
        output in_ready, ld, feed_out, re0, re1, out_valid, out_id,
               out_score, busy, err
    );
endinterface

// File: rtl/sm_dispatch_ctrl.sv
// Dispatches host records to the SM feeder and pairs returned scores with their IDs.
// Latency: ld 2 cycles after accept; result capture same cycle as pulse, visible next cycle.
// Backpressure: in_ready drops unless every in-flight result is guaranteed a result slot.
module sm_dispatch_ctrl #(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int SCORE_WIDTH   = 16,
    parameter int OUT_DEPTH     = 4
) (
    input logic              clk,
    input logic              rst,
    sm_dispatch_ctrl_if.slave io_bus
);
    localparam int IN_WIDTH = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH;
    localparam int AW       = $clog2(OUT_DEPTH);
    localparam int CW       = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GUARD} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [SCORE_WIDTH-1:0] score;
    } res_t;

    state_t              r_state;
    logic                r_ld;
    logic [IN_WIDTH-1:0] r_feed_out;
    logic [CW-1:0]       r_outstanding;
    logic [CW-1:0]       r_count;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic                r_pend_vld;
    res_t                r_pend;
    logic                r_err;
    res_t                r_mem [OUT_DEPTH];

    logic                w_cap0;
    logic                w_cap1;
    logic                w_accept;
    logic                w_in_ready;
    logic                w_load;
    logic                w_pop;
    logic [CW:0]         w_credit_sum;
    res_t                w_e0;
    res_t                w_e1;
    res_t                w_wa;
    res_t                w_wb;
    logic [1:0]          w_nwr;
    logic                w_pend_vld_nxt;
    res_t                w_pend_nxt;

    // A pulse only counts when a load is actually outstanding; lane 1 needs a
    // second credit if lane 0 consumed one in the same cycle.
    assign w_cap0 = io_bus.res_valid0 & (r_outstanding != '0);
    assign w_cap1 = io_bus.res_valid1 & (r_outstanding > CW'(w_cap0));

    assign w_e0 = '{id: io_bus.id0, score: io_bus.score0};
    assign w_e1 = '{id: io_bus.id1, score: io_bus.score1};

    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_count} + (CW+1)'(r_pend_vld);
    assign w_in_ready   = (r_state == ST_IDLE) & ~io_bus.feeder_full
                        & (w_credit_sum < (CW+1)'(OUT_DEPTH));
    assign w_accept     = io_bus.in_valid & w_in_ready;
    assign w_load       = (r_state == ST_LOAD);
    assign w_pop        = (r_count != '0) & io_bus.out_ready;

    // Load sequencer: accept -> pulse ld -> one guard cycle so feeder_full settles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ld          <= 1'b0;
            r_feed_out    <= '0;
            r_outstanding <= '0;
        end else begin
            r_ld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_feed_out <= io_bus.in_data;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_ld    <= 1'b1;
                    r_state <= ST_GUARD;
                end
                ST_GUARD: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
            r_outstanding <= r_outstanding + CW'(w_load) - CW'(w_cap0) - CW'(w_cap1);
        end
    end

    // Order results as pend, lane 0, lane 1; the last one left over parks in pend.
    always_comb begin
        w_wa           = r_pend;
        w_wb           = w_e0;
        w_nwr          = 2'd0;
        w_pend_vld_nxt = 1'b0;
        w_pend_nxt     = r_pend;
        case ({r_pend_vld, w_cap0, w_cap1})
            3'b001: begin w_wa = w_e1; w_nwr = 2'd1; end
            3'b010: begin w_wa = w_e0; w_nwr = 2'd1; end
            3'b011: begin
                w_wa = w_e0; w_nwr = 2'd1; w_pend_vld_nxt = 1'b1; w_pend_nxt = w_e1;
            end
            3'b100: w_nwr = 2'd1;
            3'b101: begin w_nwr = 2'd1; w_pend_vld_nxt = 1'b1; w_pend_nxt = w_e1; end
            3'b110: begin w_nwr = 2'd1; w_pend_vld_nxt = 1'b1; w_pend_nxt = w_e0; end
            // pend plus both lanes: two FIFO writes so nothing is lost
            3'b111: begin w_nwr = 2'd2; w_pend_vld_nxt = 1'b1; w_pend_nxt = w_e1; end
            default: ;
        endcase
    end

    // Result FIFO pointers, pend register and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + AW'(w_nwr);
            r_rptr     <= r_rptr + AW'(w_pop);
            r_count    <= r_count + CW'(w_nwr) - CW'(w_pop);
            r_pend_vld <= w_pend_vld_nxt;
            r_pend     <= w_pend_nxt;
            if ((io_bus.res_valid0 & ~w_cap0) | (io_bus.res_valid1 & ~w_cap1))
                r_err <= 1'b1;
        end
    end

    // Result storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_nwr != 2'd0)
            r_mem[r_wptr] <= w_wa;
        if (w_nwr == 2'd2)
            r_mem[r_wptr + AW'(1)] <= w_wb;
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.ld        = r_ld;
    assign io_bus.feed_out  = r_feed_out;
    assign io_bus.re0       = w_cap0;
    assign io_bus.re1       = w_cap1;
    assign io_bus.out_valid = (r_count != '0);
    assign io_bus.out_id    = r_mem[r_rptr].id;
    assign io_bus.out_score = r_mem[r_rptr].score;
    assign io_bus.busy      = (r_outstanding != '0) | (r_count != '0) | r_pend_vld
                            | (r_state != ST_IDLE);
    assign io_bus.err       = r_err;
endmodule
